ulpi_reg_access: RTL and testbench

//  Link-side ULPI register-access master for the USB3300 sniffer: issues register

---
 rtl/ulpi_reg_access.sv | 211 +++++++++++++++++++++
 tb/tb_ulpi_reg_access.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_access.sv
// Link-side ULPI register-access master: turns a req/done register request into
// a TXCMD/NXT/STP write or read handshake on the ULPI bus, with DIR steal and timeout.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no transaction; busy clears one cycle after done/abort
// WAIT_BUS | request latched, PHY owns the bus (dir=1), waiting for release
// W_CMD    | driving register-write TXCMD {10,addr}, waiting for nxt
// W_DATA   | driving write data, waiting for nxt
// W_STP    | one-cycle stp with NOOP on the bus, then done
// R_CMD    | driving register-read TXCMD {11,addr}, waiting for nxt
// R_TURN   | bus released, waiting for PHY to take it (dir=1 turnaround)
// R_DATA   | capture register value from the PHY
// R_END    | waiting for PHY to hand the bus back (dir=0), then done
module ulpi_reg_access #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [5:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       abort,
    output logic       busy,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_BUS,
        W_CMD,
        W_DATA,
        W_STP,
        R_CMD,
        R_TURN,
        R_DATA,
        R_END
    } state_t;

    state_t        state;
    logic          lat_rw;
    logic [5:0]    lat_addr;
    logic [7:0]    lat_wdata;
    logic [TW-1:0] tmr;
    logic          tmr_done;
    logic [7:0]    cmd_byte;

    // Down-counter reloaded on every state change; reaching zero in a wait state
    // means TIMEOUT_CYCLES cycles have been spent there.
    assign tmr_done = (tmr == '0);
    assign cmd_byte = {1'b1, lat_rw, lat_addr};

    // Released combinationally so the link never fights the PHY in the DIR-rise cycle.
    assign ulpi_data_oe = !ulpi_dir && !rst &&
                          !((state == R_TURN) || (state == R_DATA) || (state == R_END));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lat_rw        <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            tmr           <= TMR_LOAD;
            rdata         <= '0;
            done          <= 1'b0;
            abort         <= 1'b0;
            busy          <= 1'b0;
            ulpi_stp      <= 1'b0;
            ulpi_data_out <= '0;
        end else begin
            done          <= 1'b0;
            abort         <= 1'b0;
            ulpi_stp      <= 1'b0;
            ulpi_data_out <= '0;
            tmr           <= tmr - TW'(1);

            case (state)
                IDLE: begin
                    tmr  <= TMR_LOAD;
                    busy <= 1'b0;
                    if (req && !busy) begin
                        lat_rw    <= rw;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        busy      <= 1'b1;
                        if (!ulpi_dir) begin
                            state         <= rw ? R_CMD : W_CMD;
                            ulpi_data_out <= {1'b1, rw, addr};
                        end else begin
                            state <= WAIT_BUS;
                        end
                    end
                end

                WAIT_BUS: begin
                    if (!ulpi_dir) begin
                        state         <= lat_rw ? R_CMD : W_CMD;
                        ulpi_data_out <= cmd_byte;
                        tmr           <= TMR_LOAD;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end
                end

                W_CMD: begin
                    if (ulpi_dir) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end else if (ulpi_nxt) begin
                        state         <= W_DATA;
                        ulpi_data_out <= lat_wdata;
                        tmr           <= TMR_LOAD;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end else begin
                        ulpi_data_out <= cmd_byte;
                    end
                end

                W_DATA: begin
                    if (ulpi_dir) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end else if (ulpi_nxt) begin
                        state    <= W_STP;
                        ulpi_stp <= 1'b1;
                        tmr      <= TMR_LOAD;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end else begin
                        ulpi_data_out <= lat_wdata;
                    end
                end

                W_STP: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    tmr   <= TMR_LOAD;
                end

                R_CMD: begin
                    if (ulpi_dir) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end else if (ulpi_nxt) begin
                        state <= R_TURN;
                        tmr   <= TMR_LOAD;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end else begin
                        ulpi_data_out <= cmd_byte;
                    end
                end

                R_TURN: begin
                    if (ulpi_dir) begin
                        state <= R_DATA;
                        tmr   <= TMR_LOAD;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end
                end

                // PHY dropping dir here means no register data ever arrived.
                R_DATA: begin
                    tmr <= TMR_LOAD;
                    if (ulpi_dir) begin
                        rdata <= ulpi_data_in;
                        state <= R_END;
                    end else begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end
                end

                R_END: begin
                    if (!ulpi_dir) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        tmr   <= TMR_LOAD;
                    end else if (tmr_done) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tmr   <= TMR_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed bench for ulpi_reg_access: stimulus pushes expected done/abort outcomes
// into a scoreboard that a negedge monitor pops; bus-level details are checked inline.
module tb_ulpi_reg_access;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       rw;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       done;
    logic       abort;
    logic       busy;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    logic [7:0] ulpi_data_in;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_abort;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   busy_chk_next = 1'b0;
    logic [7:0] rd_model = 8'h00;

    ulpi_reg_access #(.TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .rw           (rw),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .done         (done),
        .abort        (abort),
        .busy         (busy),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_stp     (ulpi_stp),
        .ulpi_data_in (ulpi_data_in),
        .ulpi_data_out(ulpi_data_out),
        .ulpi_data_oe (ulpi_data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic issue(input logic r, input logic [5:0] a, input logic [7:0] d);
        req   = 1'b1;
        rw    = r;
        addr  = a;
        wdata = d;
    endtask

    task automatic expect_end(input bit ab, input logic [7:0] rd);
        exp_t e;
        e.is_abort = ab;
        e.rd       = rd;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every done/abort pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (busy_chk_next) begin
            busy_chk_next = 1'b0;
            check("busy_after_end", 16'(busy), 16'h0);
        end
        if (!rst && (done || abort)) begin
            check("done_abort_excl", 16'(done && abort), 16'h0);
            if (sb.size() == 0) begin
                check("unexpected_end", 16'({done, abort}), 16'h0);
            end else begin
                mon_e = sb.pop_front();
                check("end_kind", 16'({done, abort}), mon_e.is_abort ? 16'h1 : 16'h2);
                check("end_rdata", 16'(rdata), 16'(mon_e.rd));
                check("end_busy", 16'(busy), 16'h1);
            end
            busy_chk_next = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = '0;
        repeat (3) tick();
        at_neg();
        check("rst_oe", 16'(ulpi_data_oe), 16'h0);
        check("rst_out", 16'({busy, done, abort, ulpi_stp}), 16'h0);
        check("rst_data", 16'(ulpi_data_out), 16'h0);
        check("rst_rdata", 16'(rdata), 16'h0);
        tick();
        rst = 1'b0;
        at_neg();
        check("idle_oe", 16'(ulpi_data_oe), 16'h1);

        // 1: register write 0x0A <= 0x45, nxt arrives in the second TXCMD cycle
        tick();
        issue(1'b0, 6'h0A, 8'h45);
        expect_end(1'b0, rd_model);
        tick();
        req = 1'b0;
        at_neg();
        check("t1_txcmd", 16'(ulpi_data_out), 16'h8A);
        check("t1_busy", 16'(busy), 16'h1);
        tick();
        ulpi_nxt = 1'b1;
        at_neg();
        check("t1_txcmd_hold", 16'(ulpi_data_out), 16'h8A);
        tick();
        at_neg();
        check("t1_wdata", 16'(ulpi_data_out), 16'h45);
        check("t1_stp_low", 16'(ulpi_stp), 16'h0);
        tick();
        ulpi_nxt = 1'b0;
        at_neg();
        check("t1_stp", 16'({ulpi_stp, ulpi_data_out}), 16'h100);
        tick();
        at_neg();
        check("t1_done", 16'(done), 16'h1);
        check("t1_stp_off", 16'(ulpi_stp), 16'h0);
        repeat (2) tick();

        // 2: register read 0x16, PHY returns 0xA5
        issue(1'b1, 6'h16, 8'h00);
        rd_model = 8'hA5;
        expect_end(1'b0, rd_model);
        tick();
        req = 1'b0;
        at_neg();
        check("t2_txcmd", 16'(ulpi_data_out), 16'hD6);
        check("t2_oe_cmd", 16'(ulpi_data_oe), 16'h1);
        tick();
        ulpi_nxt = 1'b1;
        tick();
        ulpi_nxt = 1'b0;
        ulpi_dir = 1'b1;
        at_neg();
        check("t2_oe_turn", 16'(ulpi_data_oe), 16'h0);
        tick();
        ulpi_data_in = 8'hA5;
        at_neg();
        check("t2_oe_data", 16'(ulpi_data_oe), 16'h0);
        tick();
        ulpi_dir = 1'b0;
        ulpi_data_in = 8'h00;
        at_neg();
        check("t2_oe_end", 16'(ulpi_data_oe), 16'h0);
        tick();
        at_neg();
        check("t2_done", 16'({done, rdata}), 16'h1A5);
        check("t2_oe_back", 16'(ulpi_data_oe), 16'h1);
        repeat (2) tick();

        // 3: write stolen by DIR during the data phase
        issue(1'b0, 6'h05, 8'h33);
        expect_end(1'b1, rd_model);
        tick();
        req = 1'b0;
        ulpi_nxt = 1'b1;
        tick();
        ulpi_nxt = 1'b0;
        ulpi_dir = 1'b1;
        at_neg();
        check("t3_oe_same_cycle", 16'(ulpi_data_oe), 16'h0);
        tick();
        at_neg();
        check("t3_abort", 16'({abort, ulpi_stp}), 16'h2);
        tick();
        ulpi_dir = 1'b0;
        at_neg();
        check("t3_busy_low", 16'(busy), 16'h0);
        tick();

        // 4: nxt never arrives, abort TIMEOUT_CYCLES after W_CMD entry
        issue(1'b0, 6'h01, 8'h02);
        expect_end(1'b1, rd_model);
        tick();
        req = 1'b0;
        at_neg();
        check("t4_txcmd", 16'(ulpi_data_out), 16'h81);
        n = 0;
        while (!abort && n < 200) begin
            at_neg();
            n++;
        end
        check("t4_timeout_cycles", 16'(n), 16'd64);
        check("t4_stp", 16'(ulpi_stp), 16'h0);
        repeat (2) tick();

        // 5: request while PHY owns the bus; a second request while busy is dropped
        ulpi_dir = 1'b1;
        tick();
        issue(1'b0, 6'h2A, 8'h5C);
        expect_end(1'b0, rd_model);
        tick();
        req = 1'b0;
        at_neg();
        check("t5_wait_oe", 16'(ulpi_data_oe), 16'h0);
        check("t5_wait_busy", 16'(busy), 16'h1);
        tick();
        issue(1'b1, 6'h3F, 8'hEE);
        tick();
        req = 1'b0;
        ulpi_dir = 1'b0;
        at_neg();
        check("t5_noop_on_release", 16'(ulpi_data_out), 16'h00);
        tick();
        ulpi_nxt = 1'b1;
        at_neg();
        check("t5_txcmd", 16'(ulpi_data_out), 16'hAA);
        tick();
        at_neg();
        check("t5_wdata", 16'(ulpi_data_out), 16'h5C);
        tick();
        ulpi_nxt = 1'b0;
        repeat (4) tick();
        at_neg();
        check("t5_no_queue", 16'({busy, ulpi_data_out}), 16'h000);

        // 6: reset during R_END, then a minimum-latency write
        issue(1'b1, 6'h07, 8'h00);
        tick();
        req = 1'b0;
        ulpi_nxt = 1'b1;
        tick();
        ulpi_nxt = 1'b0;
        ulpi_dir = 1'b1;
        tick();
        ulpi_data_in = 8'h3C;
        tick();
        rst = 1'b1;
        ulpi_data_in = 8'h00;
        tick();
        rd_model = 8'h00;
        at_neg();
        check("t6_rst_oe", 16'(ulpi_data_oe), 16'h0);
        check("t6_rst_out", 16'({busy, done, abort, ulpi_stp}), 16'h0);
        check("t6_rst_bus", 16'({rdata, ulpi_data_out}), 16'h0000);
        tick();
        rst = 1'b0;
        ulpi_dir = 1'b0;
        tick();
        issue(1'b0, 6'h10, 8'hFF);
        ulpi_nxt = 1'b1;
        expect_end(1'b0, rd_model);
        tick();
        req = 1'b0;
        at_neg();
        check("t6_txcmd", 16'(ulpi_data_out), 16'h90);
        tick();
        at_neg();
        check("t6_wdata", 16'(ulpi_data_out), 16'hFF);
        tick();
        ulpi_nxt = 1'b0;
        tick();
        at_neg();
        check("t6_done_latency", 16'(done), 16'h1);
        repeat (3) tick();

        check("scoreboard_empty", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
